// File: rtl/uart_pkg.sv
// Shared definitions for the epRISC UART register bus and the TX arbiter FSM.
package uart_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_TXDATA = 2'd1;
  localparam logic [1:0] ADDR_RXDATA = 2'd2;

  localparam int unsigned RECV_ACT = 4;
  localparam int unsigned RECV_EN  = 5;
  localparam int unsigned SEND_ACT = 6;
  localparam int unsigned SEND_EN  = 7;
  localparam int unsigned INT_EN   = 8;

  typedef enum logic [2:0] {
    ST_ARB,
    ST_WR_DATA,
    ST_WR_CTRL,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_DONE
  } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or after the pointer.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    logic found;
    int unsigned j;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(ptr_i) + i) % NREQ;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one epRISC UART among NREQ byte requesters: round-robin grant, write
// TX data, arm send-enable, then poll control until the frame ends or times out.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int          NREQ       = 4,
  parameter logic [15:0] CTRL_CFG   = 16'h0020,
  parameter int          POLL_LIMIT = 65535
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [NREQ-1:0]   iReqValid,
  input  logic [8*NREQ-1:0] iReqData,
  output logic [NREQ-1:0]   oReqAck,
  output logic              oReqErr,
  output logic              oBusy,
  output logic [1:0]        oAddr,
  output logic [15:0]       oData,
  output logic              oWrite,
  output logic              oEnable,
  input  logic [15:0]       iData
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(POLL_LIMIT);
  // Status bits must never be written back; send-enable is always armed.
  localparam logic [15:0] CTRL_MASK = ~((16'd1 << SEND_EN) | (16'd1 << SEND_ACT) |
                                        (16'd1 << RECV_ACT));
  localparam logic [15:0] CTRL_WORD = (CTRL_CFG & CTRL_MASK) | (16'd1 << SEND_EN);

  tx_state_e       state_q;
  logic [IW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] ack_q;
  logic            err_q;
  logic            busy_q;
  logic [1:0]      addr_q;
  logic [15:0]     data_q;
  logic            wr_q;
  logic            en_q;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            timeout;
  logic            start_ok;
  logic            done_ok;
  logic            unused_idata;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i   (iReqValid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  assign timeout      = (cnt_q == LIMIT);
  assign start_ok     = iData[SEND_ACT] | ~iData[SEND_EN];
  assign done_ok      = ~iData[SEND_ACT] & ~iData[SEND_EN];
  assign unused_idata = ^{iData[15:8], iData[5:0]};

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        ST_ARB: begin
          if (|grant) begin
            gnt_q   <= grant;
            ptr_q   <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            busy_q  <= 1'b1;
            addr_q  <= ADDR_TXDATA;
            data_q  <= {8'h00, iReqData[gidx*8 +: 8]};
            wr_q    <= 1'b1;
            en_q    <= 1'b1;
            state_q <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          addr_q  <= ADDR_CTRL;
          data_q  <= CTRL_WORD;
          state_q <= ST_WR_CTRL;
        end
        ST_WR_CTRL: begin
          cnt_q   <= '0;
          data_q  <= '0;
          wr_q    <= 1'b0;
          state_q <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (timeout) begin
            ack_q   <= gnt_q;
            err_q   <= 1'b1;
            en_q    <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (start_ok) state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (timeout || done_ok) begin
            ack_q   <= gnt_q;
            err_q   <= timeout;
            en_q    <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_ARB;
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  assign oReqAck = ack_q;
  assign oReqErr = err_q;
  assign oBusy   = busy_q;
  assign oAddr   = addr_q;
  assign oData   = data_q;
  assign oWrite  = wr_q;
  assign oEnable = en_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: directed requests push expected bus writes and acks; a
// monitor per DUT pops and compares whenever a write or ack appears.
module tb_uart_tx_arbiter;

  typedef struct {
    int          kind;   // 0 = bus write, 1 = ack
    logic [1:0]  addr;
    logic [15:0] data;
    logic [3:0]  ack;
    logic        err;
    int          lat;    // cycles from control write to ack, 0 = don't care
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_pass;
  exp_t qa[$];
  exp_t qb[$];

  logic [3:0]  a_valid, a_ack;
  logic [31:0] a_data;
  logic        a_err, a_busy, a_wr, a_en;
  logic [1:0]  a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic        fast;
  int unsigned tcnt;

  logic [3:0]  b_valid, b_ack;
  logic [31:0] b_data;
  logic        b_err, b_busy, b_wr, b_en;
  logic [1:0]  b_addr;
  logic [15:0] b_wdata, b_rdata;

  uart_tx_arbiter #(
    .NREQ       (4),
    .CTRL_CFG   (16'h0020),
    .POLL_LIMIT (100)
  ) u_dut (
    .iClk      (clk),
    .iRst      (rst_n),
    .iReqValid (a_valid),
    .iReqData  (a_data),
    .oReqAck   (a_ack),
    .oReqErr   (a_err),
    .oBusy     (a_busy),
    .oAddr     (a_addr),
    .oData     (a_wdata),
    .oWrite    (a_wr),
    .oEnable   (a_en),
    .iData     (a_rdata)
  );

  uart_tx_arbiter #(
    .NREQ       (4),
    .CTRL_CFG   (16'h01F0),
    .POLL_LIMIT (16)
  ) u_to (
    .iClk      (clk),
    .iRst      (rst_n),
    .iReqValid (b_valid),
    .iReqData  (b_data),
    .oReqAck   (b_ack),
    .oReqErr   (b_err),
    .oBusy     (b_busy),
    .oAddr     (b_addr),
    .oData     (b_wdata),
    .oWrite    (b_wr),
    .oEnable   (b_en),
    .iData     (b_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART model: send-enable held 3 cycles after the control write, then send
  // active until cycle 20; fast mode reports an already-finished frame.
  always @(negedge clk) begin
    if (a_en && a_wr && a_addr == 2'd0) tcnt <= 0;
    else if (tcnt < 1000) tcnt <= tcnt + 1;
  end
  assign a_rdata = fast ? 16'h0000 :
                   {8'h00, (tcnt < 3), (tcnt >= 3 && tcnt < 20), 6'b110011};
  assign b_rdata = 16'h0080;

  task automatic cmp(input string nm, input exp_t e, input int kind, input logic [1:0] addr,
                     input logic [15:0] data, input logic [3:0] ack, input logic err,
                     input int lat);
    logic ok;
    n_chk++;
    if (kind == 0) ok = (e.kind == 0) && addr == e.addr && data == e.data;
    else ok = (e.kind == 1) && ack == e.ack && err == e.err && (e.lat == 0 || lat == e.lat);
    if (ok) n_pass++;
    else $display("FAIL %s: got kind=%0d addr=%0d data=%h ack=%b err=%b lat=%0d; want kind=%0d addr=%0d data=%h ack=%b err=%b lat=%0d",
                  nm, kind, addr, data, ack, err, lat, e.kind, e.addr, e.data, e.ack, e.err, e.lat);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, got, want);
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    $display("FAIL %s: got an event with empty expectation queue, want none", nm);
  endtask

  task automatic push_tx(input int which, input logic [7:0] b, input logic [15:0] ctrl,
                         input logic [3:0] ack, input logic err, input int lat);
    exp_t e[3];
    e[0] = '{0, 2'd1, {8'h00, b}, 4'h0, 1'b0, 0};
    e[1] = '{0, 2'd0, ctrl, 4'h0, 1'b0, 0};
    e[2] = '{1, 2'd0, 16'h0, ack, err, lat};
    for (int i = 0; i < 3; i++) begin
      if (which == 0) qa.push_back(e[i]);
      else qb.push_back(e[i]);
    end
  endtask

  // k < 0 waits for any ack bit
  task automatic wait_ack(input int which, input int k);
    int n;
    int kk;
    logic [3:0] v;
    logic got;
    n = 0;
    kk = (k < 0) ? 0 : k;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      v = (which == 0) ? a_ack : b_ack;
      got = (k < 0) ? (|v) : v[kk];
    end
    n_chk++;
    if (got) n_pass++;
    else $display("FAIL wait_ack dut%0d req%0d: got no ack in %0d cycles, want ack", which, k, n);
  endtask

  task automatic wait_ctrl_write();
    int n;
    n = 0;
    while (!(a_en && a_wr && a_addr == 2'd0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (a_en && a_wr && a_addr == 2'd0) n_pass++;
    else $display("FAIL wait_ctrl: got no control write in %0d cycles, want one", n);
  endtask

  initial begin : mon_a
    int t_ctrl;
    exp_t e;
    t_ctrl = 0;
    forever begin
      @(negedge clk);
      if (a_en && a_wr) begin
        if (a_addr == 2'd0) t_ctrl = cyc;
        if (qa.size() == 0) unexpected("main_write");
        else begin
          e = qa.pop_front();
          cmp("main_write", e, 0, a_addr, a_wdata, 4'h0, 1'b0, 0);
        end
      end
      if (|a_ack) begin
        if (qa.size() == 0) unexpected("main_ack");
        else begin
          e = qa.pop_front();
          cmp("main_ack", e, 1, 2'd0, 16'h0, a_ack, a_err, cyc - t_ctrl);
        end
      end
    end
  end

  initial begin : mon_b
    int t_ctrl;
    exp_t e;
    t_ctrl = 0;
    forever begin
      @(negedge clk);
      if (b_en && b_wr) begin
        if (b_addr == 2'd0) t_ctrl = cyc;
        if (qb.size() == 0) unexpected("to_write");
        else begin
          e = qb.pop_front();
          cmp("to_write", e, 0, b_addr, b_wdata, 4'h0, 1'b0, 0);
        end
      end
      if (|b_ack) begin
        if (qb.size() == 0) unexpected("to_ack");
        else begin
          e = qb.pop_front();
          cmp("to_ack", e, 1, 2'd0, 16'h0, b_ack, b_err, cyc - t_ctrl);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; cyc = 0; n_chk = 0; n_pass = 0; tcnt = 1000; fast = 1'b0;
    a_valid = '0; a_data = '0; b_valid = '0; b_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_main", 32'({a_ack, a_err, a_busy, a_addr, a_wdata, a_wr, a_en}), 32'h0);
    chk("reset_to", 32'({b_ack, b_err, b_busy, b_addr, b_wdata, b_wr, b_en}), 32'h0);

    // Round-robin with all four requesters valid and a fast UART.
    fast = 1'b1;
    push_tx(0, 8'h10, 16'h00A0, 4'b0001, 1'b0, 3);
    push_tx(0, 8'h11, 16'h00A0, 4'b0010, 1'b0, 3);
    push_tx(0, 8'h12, 16'h00A0, 4'b0100, 1'b0, 3);
    push_tx(0, 8'h13, 16'h00A0, 4'b1000, 1'b0, 3);
    push_tx(0, 8'h10, 16'h00A0, 4'b0001, 1'b0, 3);
    a_data = 32'h1312_1110;
    a_valid = 4'b1111;
    for (int i = 0; i < 5; i++) wait_ack(0, -1);
    a_valid = '0;

    // Single request from requester 2 with a realistic frame.
    fast = 1'b0;
    @(negedge clk);
    push_tx(0, 8'hA5, 16'h00A0, 4'b0100, 1'b0, 21);
    a_data = 32'h00A5_0000;
    a_valid = 4'b0100;
    wait_ack(0, 2);
    a_valid = '0;
    chk("busy_in_done", 32'(a_busy), 32'h1);
    @(negedge clk);
    chk("busy_after_done", 32'(a_busy), 32'h0);

    // Fast UART: pointer sits at 3, requester 1 is the only one pending.
    fast = 1'b1;
    push_tx(0, 8'h3C, 16'h00A0, 4'b0010, 1'b0, 3);
    a_data = 32'h0000_3C00;
    a_valid = 4'b0010;
    wait_ack(0, 1);
    a_valid = '0;

    // Reset during WAIT_DONE: no ack, pointer back to 0.
    fast = 1'b0;
    @(negedge clk);
    qa.push_back('{0, 2'd1, 16'h0077, 4'h0, 1'b0, 0});
    qa.push_back('{0, 2'd0, 16'h00A0, 4'h0, 1'b0, 0});
    a_data = 32'h7700_0000;
    a_valid = 4'b1000;
    @(negedge clk);
    wait_ctrl_write();
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'({a_ack, a_err, a_busy, a_addr, a_wdata, a_wr, a_en}), 32'h0);
    a_data = 32'h7700_0055;
    a_valid = 4'b1001;
    push_tx(0, 8'h55, 16'h00A0, 4'b0001, 1'b0, 21);
    push_tx(0, 8'h77, 16'h00A0, 4'b1000, 1'b0, 21);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ack(0, 0);
    a_valid = 4'b1000;
    wait_ack(0, 3);
    a_valid = '0;

    // Timeout instance: UART never starts; masked control config.
    push_tx(1, 8'hE1, 16'h01A0, 4'b0001, 1'b1, 18);
    push_tx(1, 8'hE2, 16'h01A0, 4'b0010, 1'b1, 18);
    b_data = 32'h0000_E2E1;
    b_valid = 4'b0001;
    wait_ack(1, 0);
    b_valid = 4'b0010;
    wait_ack(1, 1);
    b_valid = '0;

    repeat (5) @(negedge clk);
    chk("main_queue_drained", 32'(qa.size()), 32'h0);
    chk("to_queue_drained", 32'(qb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
